// File: rtl/ifft_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : ifft_seq_if
// Brief    : Stream-in / stream-out handshake bundle for the sequential IFFT.
// Revision : 1.0  initial release
// ============================================================================
interface ifft_seq_if #(
    parameter int WIDTH = 12
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_re;
    logic signed [WIDTH-1:0] in_im;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_re;
    logic signed [WIDTH-1:0] out_im;
    logic                    out_last;
    logic                    busy;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_last, busy
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/ifft_seq.sv
`default_nettype none
// ============================================================================
// Module   : ifft_seq
// Brief    : In-place radix-2 DIT inverse FFT, one butterfly per clock, 1/N scaled.
// Revision : 1.0  initial release
// ============================================================================
module ifft_seq #(
    parameter int N     = 8,
    parameter int WIDTH = 12
) (
    input  wire logic clk,
    input  wire logic rst_n,
    ifft_seq_if.slave s
);
    localparam int C_LOG2N = $clog2(N);
    localparam int C_FRAC  = WIDTH - 2;
    localparam int C_XW    = 2*WIDTH + 1;

    typedef logic        [C_LOG2N-1:0] idx_t;
    typedef logic signed [WIDTH-1:0]   smp_t;
    typedef logic signed [C_XW-1:0]    ext_t;

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_UNLOAD  = 2'd2
    } state_t;

    localparam idx_t C_LAST_IDX   = idx_t'(N - 1);
    localparam idx_t C_LAST_BF    = idx_t'(N/2 - 1);
    localparam idx_t C_LAST_STAGE = idx_t'(C_LOG2N - 1);
    localparam ext_t C_SAT_MAX    = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam ext_t C_SAT_MIN    = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

    // Elaboration-time cos/sin via Taylor series; angle stays below 2*pi.
    function automatic real f_trig(input int k, input bit sine);
        real x, term, sum;
        x    = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
        term = sine ? x : 1.0;
        sum  = term;
        for (int i = 1; i < 24; i++) begin
            if (sine) term = -term * x * x / (real'(2*i) * real'(2*i + 1));
            else      term = -term * x * x / (real'(2*i - 1) * real'(2*i));
            sum = sum + term;
        end
        return sum;
    endfunction

    function automatic smp_t f_tw(input int k, input bit sine);
        return smp_t'(int'(f_trig(k, sine) * real'(1 << C_FRAC)));
    endfunction

    function automatic idx_t f_rev(input idx_t v);
        idx_t r;
        for (int i = 0; i < C_LOG2N; i++) r[i] = v[C_LOG2N-1-i];
        return r;
    endfunction

    function automatic ext_t f_ext(input smp_t v);
        return ext_t'(v);
    endfunction

    function automatic smp_t f_sat(input ext_t v);
        if (v > C_SAT_MAX) return C_SAT_MAX[WIDTH-1:0];
        if (v < C_SAT_MIN) return C_SAT_MIN[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    state_t r_state;
    state_t w_next;
    idx_t   r_cnt;
    idx_t   r_stage;
    idx_t   r_bf;

    smp_t   r_mem_re [N];
    smp_t   r_mem_im [N];
    smp_t   w_tw_re  [N];
    smp_t   w_tw_im  [N];

    for (genvar g = 0; g < N; g++) begin : g_tw
        localparam smp_t C_WR = f_tw(g, 1'b0);
        localparam smp_t C_WI = f_tw(g, 1'b1);
        assign w_tw_re[g] = C_WR;
        assign w_tw_im[g] = C_WI;
    end

    logic w_xfer;
    logic w_bf_last;
    idx_t w_ld_addr;
    assign w_xfer    = s.in_valid && (r_state == S_LOAD);
    assign w_bf_last = (r_bf == C_LAST_BF) && (r_stage == C_LAST_STAGE);
    assign w_ld_addr = f_rev(r_cnt);

    // Butterfly j of stage s pairs a = group*2^(s+1) + pos with b = a + 2^s.
    idx_t w_half, w_mask, w_pos, w_a_idx, w_b_idx, w_tw_idx;
    assign w_half   = idx_t'(1) << r_stage;
    assign w_mask   = w_half - idx_t'(1);
    assign w_pos    = r_bf & w_mask;
    assign w_a_idx  = ((r_bf & ~w_mask) << 1) | w_pos;
    assign w_b_idx  = w_a_idx | w_half;
    assign w_tw_idx = w_pos << (C_LAST_STAGE - r_stage);

    smp_t w_a_re, w_a_im, w_b_re, w_b_im, w_wr, w_wi;
    assign w_a_re = r_mem_re[w_a_idx];
    assign w_a_im = r_mem_im[w_a_idx];
    assign w_b_re = r_mem_re[w_b_idx];
    assign w_b_im = r_mem_im[w_b_idx];
    assign w_wr   = w_tw_re[w_tw_idx];
    assign w_wi   = w_tw_im[w_tw_idx];

    ext_t w_prod_re, w_prod_im, w_t_re, w_t_im;
    ext_t w_sum_re, w_sum_im, w_dif_re, w_dif_im;
    assign w_prod_re = f_ext(w_b_re) * f_ext(w_wr) - f_ext(w_b_im) * f_ext(w_wi);
    assign w_prod_im = f_ext(w_b_re) * f_ext(w_wi) + f_ext(w_b_im) * f_ext(w_wr);
    assign w_t_re    = w_prod_re >>> C_FRAC;
    assign w_t_im    = w_prod_im >>> C_FRAC;
    assign w_sum_re  = (f_ext(w_a_re) + w_t_re) >>> 1;
    assign w_sum_im  = (f_ext(w_a_im) + w_t_im) >>> 1;
    assign w_dif_re  = (f_ext(w_a_re) - w_t_re) >>> 1;
    assign w_dif_im  = (f_ext(w_a_im) - w_t_im) >>> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_LOAD;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:    if (w_xfer && (r_cnt == C_LAST_IDX)) w_next = S_COMPUTE;
            S_COMPUTE: if (w_bf_last) w_next = S_UNLOAD;
            S_UNLOAD:  if (s.out_ready && (r_cnt == C_LAST_IDX)) w_next = S_LOAD;
            default:   w_next = S_LOAD;
        endcase
    end

    // r_cnt wraps to zero by itself because N is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_stage <= '0;
            r_bf    <= '0;
        end else begin
            case (r_state)
                S_LOAD: if (w_xfer) r_cnt <= r_cnt + idx_t'(1);
                S_COMPUTE: begin
                    if (r_bf == C_LAST_BF) begin
                        r_bf    <= '0;
                        r_stage <= (r_stage == C_LAST_STAGE) ? '0 : r_stage + idx_t'(1);
                    end else begin
                        r_bf    <= r_bf + idx_t'(1);
                    end
                end
                S_UNLOAD: if (s.out_ready) r_cnt <= r_cnt + idx_t'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_mem_re[w_ld_addr] <= s.in_re;
            r_mem_im[w_ld_addr] <= s.in_im;
        end else if (r_state == S_COMPUTE) begin
            r_mem_re[w_a_idx] <= f_sat(w_sum_re);
            r_mem_im[w_a_idx] <= f_sat(w_sum_im);
            r_mem_re[w_b_idx] <= f_sat(w_dif_re);
            r_mem_im[w_b_idx] <= f_sat(w_dif_im);
        end
    end

    assign s.in_ready  = (r_state == S_LOAD);
    assign s.out_valid = (r_state == S_UNLOAD);
    assign s.busy      = (r_state != S_LOAD);
    assign s.out_last  = (r_state == S_UNLOAD) && (r_cnt == C_LAST_IDX);
    assign s.out_re    = (r_state == S_UNLOAD) ? r_mem_re[r_cnt] : '0;
    assign s.out_im    = (r_state == S_UNLOAD) ? r_mem_im[r_cnt] : '0;

endmodule
`default_nettype wire
